apb_gpio_arbiter: RTL and testbench



---
 rtl/apb_gpio_arbiter_if.sv | 50 +++++
 rtl/apb_gpio_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_gpio_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_gpio_arbiter_if.sv
// Bundle of the two requester channels and the APB master port of apb_gpio_arbiter.
// "master" is the arbiter's own view; "slave" is the view of the requesters plus the APB slave.
interface apb_gpio_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  r0_valid;
    logic                  r0_ready;
    logic                  r0_write;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic                  r0_rsp_valid;
    logic [DATA_WIDTH-1:0] r0_rsp_rdata;
    logic                  r0_rsp_err;

    logic                  r1_valid;
    logic                  r1_ready;
    logic                  r1_write;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic                  r1_rsp_valid;
    logic [DATA_WIDTH-1:0] r1_rsp_rdata;
    logic                  r1_rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        input  r0_valid, r0_write, r0_addr, r0_wdata,
        input  r1_valid, r1_write, r1_addr, r1_wdata,
        input  PREADY, PRDATA,
        output r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        output r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output r0_valid, r0_write, r0_addr, r0_wdata,
        output r1_valid, r1_write, r1_addr, r1_wdata,
        output PREADY, PRDATA,
        input  r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        input  r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_gpio_arbiter.sv
// Round-robin arbiter that lets two requesters share one APB slave, with a PREADY timeout
// so that a hung slave cannot lock up either requester.
module apb_gpio_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input logic                  PCLK,
    input logic                  PRESET,
    apb_gpio_arbiter_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic                  lastGrant_q, lastGrant_d;
    logic                  grant_q, grant_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic          anyValid;
    logic          winner;
    logic          ready0, ready1;
    logic [CW-1:0] cntNext;

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        anyValid = bus.r0_valid | bus.r1_valid;
        winner   = (bus.r0_valid & bus.r1_valid) ? ~lastGrant_q : bus.r1_valid;
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        ready0      = 1'b0;
        ready1      = 1'b0;
        cntNext     = cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (anyValid && !PRESET) begin
                    ready0      = ~winner;
                    ready1      = winner;
                    grant_d     = winner;
                    lastGrant_d = winner;
                    write_d     = winner ? bus.r1_write : bus.r0_write;
                    addr_d      = winner ? bus.r1_addr  : bus.r0_addr;
                    wdata_d     = winner ? bus.r1_wdata : bus.r0_wdata;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rdata_d = write_q ? '0 : bus.PRDATA;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cntNext == CW'(TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cntNext;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // lastGrant resets to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE = (state_q == ACCESS);
    assign bus.PWRITE  = write_q;
    assign bus.PADDR   = addr_q;
    assign bus.PWDATA  = wdata_q;

    assign bus.r0_ready = ready0;
    assign bus.r1_ready = ready1;

    // Response fields are forced to zero whenever their pulse is not active.
    assign bus.r0_rsp_valid = (state_q == RESP) && !grant_q;
    assign bus.r1_rsp_valid = (state_q == RESP) &&  grant_q;
    assign bus.r0_rsp_rdata = bus.r0_rsp_valid ? rdata_q : '0;
    assign bus.r1_rsp_rdata = bus.r1_rsp_valid ? rdata_q : '0;
    assign bus.r0_rsp_err   = bus.r0_rsp_valid & err_q;
    assign bus.r1_rsp_err   = bus.r1_rsp_valid & err_q;
endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Bench for apb_gpio_arbiter: directed scenarios followed by random traffic, each cycle compared
// against a transaction-timeline model of the arbiter and an APB slave driven from that model.
module tb_apb_gpio_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_gpio_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_gpio_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad   = 0;

    // Model: a transaction occupies a timeline counted from its accept cycle (k=0):
    // SETUP at k=1, ACCESS for k=2..1+accessLen, response pulse at k=2+accessLen.
    bit          mBusy;
    int          mK;
    bit          mWin;
    bit          mLast;
    bit          mWr;
    logic [31:0] mAddr;
    logic [31:0] mWdata;
    bit          mTimeout;
    int          mAccessLen;
    logic [31:0] mRdata;

    bit          rqWrite [2];
    logic [31:0] rqAddr  [2];
    logic [31:0] rqWdata [2];
    int          planWaits;
    bit          usePlanPrd;
    logic [31:0] planPrd;

    int          cyc;
    int          acceptCyc;
    int          lastLat;
    logic [31:0] lastRdata;
    logic        lastErr;
    int          grantLog[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy  = 1'b0;
        mK     = 0;
        mLast  = 1'b1;
        mWr    = 1'b0;
        mAddr  = '0;
        mWdata = '0;
    endtask

    task automatic setReq(input int who, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        rqWrite[who] = wr;
        rqAddr[who]  = addr;
        rqWdata[who] = wdata;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input bit v0, input bit v1);
        bit          haveWinner;
        bit          win;
        bit          inAccess;
        bit          lastAccess;
        bit          respCycle;
        logic        prdy;
        logic [31:0] prd;

        inAccess   = mBusy && (mK >= 2) && (mK <= 1 + mAccessLen);
        lastAccess = mBusy && (mK == 1 + mAccessLen);
        respCycle  = mBusy && (mK == 2 + mAccessLen);

        prdy = 1'($urandom_range(0, 1));
        prd  = $urandom;
        if (inAccess) prdy = lastAccess && !mTimeout;
        if (lastAccess && usePlanPrd) prd = planPrd;
        if (lastAccess && !mWr && !mTimeout) mRdata = prd;

        bus.r0_valid = v0;
        bus.r0_write = rqWrite[0];
        bus.r0_addr  = rqAddr[0];
        bus.r0_wdata = rqWdata[0];
        bus.r1_valid = v1;
        bus.r1_write = rqWrite[1];
        bus.r1_addr  = rqAddr[1];
        bus.r1_wdata = rqWdata[1];
        bus.PREADY   = prdy;
        bus.PRDATA   = prd;
        #1;

        haveWinner = !mBusy && (v0 || v1);
        if (v0 && v1) win = (mLast == 1'b0);
        else          win = v1;

        checkOutput("r0_ready", bus.r0_ready, haveWinner && !win);
        checkOutput("r1_ready", bus.r1_ready, haveWinner && win);
        checkOutput("PSEL",     bus.PSEL,     mBusy && (mK >= 1) && (mK <= 1 + mAccessLen));
        checkOutput("PENABLE",  bus.PENABLE,  inAccess);
        checkOutput("PADDR",    bus.PADDR,    mAddr);
        checkOutput("PWRITE",   bus.PWRITE,   mWr);
        checkOutput("PWDATA",   bus.PWDATA,   mWdata);
        checkOutput("r0_rsp_valid", bus.r0_rsp_valid, respCycle && !mWin);
        checkOutput("r1_rsp_valid", bus.r1_rsp_valid, respCycle && mWin);
        if (respCycle && !mWin) begin
            checkOutput("r0_rsp_rdata", bus.r0_rsp_rdata, mRdata);
            checkOutput("r0_rsp_err",   bus.r0_rsp_err,   mTimeout);
        end
        if (respCycle && mWin) begin
            checkOutput("r1_rsp_rdata", bus.r1_rsp_rdata, mRdata);
            checkOutput("r1_rsp_err",   bus.r1_rsp_err,   mTimeout);
        end

        if (bus.r0_ready) begin grantLog.push_back(0); acceptCyc = cyc; end
        if (bus.r1_ready) begin grantLog.push_back(1); acceptCyc = cyc; end
        if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
            lastLat   = cyc - acceptCyc;
            lastRdata = bus.r0_rsp_valid ? bus.r0_rsp_rdata : bus.r1_rsp_rdata;
            lastErr   = bus.r0_rsp_valid ? bus.r0_rsp_err   : bus.r1_rsp_err;
        end

        if (haveWinner) begin
            mBusy      = 1'b1;
            mK         = 1;
            mWin       = win;
            mLast      = win;
            mWr        = rqWrite[win];
            mAddr      = rqAddr[win];
            mWdata     = rqWdata[win];
            mTimeout   = (planWaits >= TO);
            mAccessLen = mTimeout ? TO : planWaits + 1;
            mRdata     = '0;
        end else if (respCycle) begin
            mBusy = 1'b0;
        end else if (mBusy) begin
            mK++;
        end

        cyc++;
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic runUntilIdle();
        for (int n = 0; n < 64 && mBusy; n++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic applyReset();
        PRESET       = 1'b1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        checkOutput("rst_PSEL",     bus.PSEL,         1'b0);
        checkOutput("rst_PENABLE",  bus.PENABLE,      1'b0);
        checkOutput("rst_PWRITE",   bus.PWRITE,       1'b0);
        checkOutput("rst_PADDR",    bus.PADDR,        32'h0);
        checkOutput("rst_PWDATA",   bus.PWDATA,       32'h0);
        checkOutput("rst_r0_ready", bus.r0_ready,     1'b0);
        checkOutput("rst_r1_ready", bus.r1_ready,     1'b0);
        checkOutput("rst_r0_rsp",   bus.r0_rsp_valid, 1'b0);
        checkOutput("rst_r1_rsp",   bus.r1_rsp_valid, 1'b0);
        checkOutput("rst_r0_rdata", bus.r0_rsp_rdata, 32'h0);
        checkOutput("rst_r1_err",   bus.r1_rsp_err,   1'b0);
        modelReset();
        PRESET = 1'b0;
    endtask

    initial begin
        PRESET = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_write = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0;
        bus.r1_valid = 1'b0; bus.r1_write = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
        bus.PREADY = 1'b0; bus.PRDATA = '0;
        for (int i = 0; i < 2; i++) setReq(i, 1'b0, 32'h0, 32'h0);
        planWaits = 0; usePlanPrd = 1'b0; planPrd = '0;
        cyc = 0; acceptCyc = 0; lastLat = 0; lastRdata = '0; lastErr = 1'b0;
        modelReset();
        @(negedge PCLK);
        applyReset();

        // r0 write with zero wait states.
        setReq(0, 1'b1, 32'h4, 32'hA5A5_0001);
        planWaits = 0;
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("lat_write", lastLat, 3);
        checkOutput("write_rdata", lastRdata, 32'h0);

        // r1 read with three wait states returning 0xF0.
        setReq(1, 1'b0, 32'h0, 32'h1234_5678);
        planWaits = 3; usePlanPrd = 1'b1; planPrd = 32'h0000_00F0;
        applyStimulus(1'b0, 1'b1);
        runUntilIdle();
        usePlanPrd = 1'b0;
        checkOutput("lat_read_wait3", lastLat, 6);
        checkOutput("read_rdata_f0", lastRdata, 32'hF0);

        // Continuous contention right after reset alternates r0, r1, r0, r1.
        applyReset();
        planWaits = 0;
        grantLog.delete();
        setReq(0, 1'b1, 32'h10, 32'hAAAA_0000);
        setReq(1, 1'b0, 32'h14, 32'hBBBB_0000);
        repeat (16) applyStimulus(1'b1, 1'b1);
        checkOutput("rr_grant_count", grantLog.size(), 4);
        for (int i = 0; i < grantLog.size() && i < 4; i++)
            checkOutput("rr_grant_order", grantLog[i], i % 2);
        runUntilIdle();

        // Stuck slave times out, then the boundary case just under the limit, then a normal one.
        setReq(0, 1'b0, 32'h8, 32'h0);
        planWaits = TO;
        applyStimulus(1'b1, 1'b0);
        runUntilIdle();
        checkOutput("timeout_lat", lastLat, TO + 2);
        checkOutput("timeout_err", lastErr, 1'b1);
        checkOutput("timeout_rdata", lastRdata, 32'h0);
        setReq(1, 1'b1, 32'h18, 32'hCAFE_0001);
        planWaits = TO - 1;
        applyStimulus(1'b0, 1'b1);
        runUntilIdle();
        checkOutput("edge_wait_err", lastErr, 1'b0);
        checkOutput("edge_wait_lat", lastLat, TO + 2);
        setReq(0, 1'b0, 32'h1C, 32'h0);
        planWaits = 0;
        applyStimulus(1'b1, 1'b0);
        runUntilIdle();
        checkOutput("after_timeout_err", lastErr, 1'b0);

        // Reset lands in the ACCESS phase of an r0 read; the transfer is dropped.
        setReq(0, 1'b0, 32'hC, 32'h0);
        planWaits = 6;
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyReset();
        repeat (3) applyStimulus(1'b0, 1'b0);
        setReq(1, 1'b1, 32'h20, 32'h5555_AAAA);
        planWaits = 1;
        applyStimulus(1'b0, 1'b1);
        runUntilIdle();
        checkOutput("post_reset_err", lastErr, 1'b0);
        grantLog.delete();
        planWaits = 0;
        applyStimulus(1'b1, 1'b1);
        checkOutput("post_reset_grant_count", grantLog.size(), 1);
        if (grantLog.size() > 0) checkOutput("post_reset_r0_wins", grantLog[0], 0);
        runUntilIdle();

        // Random traffic with changing request fields, wait states, timeouts and resets.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 149) == 0) applyReset();
            for (int r = 0; r < 2; r++)
                setReq(r, 1'($urandom_range(0, 1)), $urandom, $urandom);
            case ($urandom_range(0, 19))
                0:       planWaits = TO;
                1:       planWaits = TO - 1;
                default: planWaits = $urandom_range(0, 3);
            endcase
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        runUntilIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
